// File: rtl/otter_mdu_pkg.sv
// Shared types and decode helpers for the OTTER RV32M multiply/divide unit.
package otter_mdu_pkg;

    typedef enum logic [2:0] {
        FUN_MUL    = 3'b000,
        FUN_MULH   = 3'b001,
        FUN_MULHSU = 3'b010,
        FUN_MULHU  = 3'b011,
        FUN_DIV    = 3'b100,
        FUN_DIVU   = 3'b101,
        FUN_REM    = 3'b110,
        FUN_REMU   = 3'b111
    } mdu_fun_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    // Divide-class operations all have funct3[2] set.
    function automatic logic is_div(input logic [2:0] fun);
        return fun[2];
    endfunction

    // Remainder-class operations (REM/REMU) have funct3[1] set among divides.
    function automatic logic is_rem(input logic [2:0] fun);
        return fun[2] & fun[1];
    endfunction

    // srcA is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic is_signed_a(input logic [2:0] fun);
        return (fun == FUN_MULH) || (fun == FUN_MULHSU) ||
               (fun == FUN_DIV)  || (fun == FUN_REM);
    endfunction

    // srcB is treated as signed for MULH, DIV and REM only.
    function automatic logic is_signed_b(input logic [2:0] fun);
        return (fun == FUN_MULH) || (fun == FUN_DIV) || (fun == FUN_REM);
    endfunction

endpackage

// File: rtl/otter_mdu.sv
// Iterative RV32M multiply/divide unit: magnitudes are iterated one bit per
// cycle in a shared 2*XLEN accumulator and the sign is fixed on entry to DONE.
module otter_mdu
    import otter_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      mdu_fun,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        state_q, state_d;
    mdu_fun_t          fun_q, fun_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0] acc_q, acc_d;       // {hi, lo} product or {rem, quo}
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Operand decode at the accept point.
    logic              in_sign_a, in_sign_b;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, fast_path;
    logic [XLEN-1:0]   fast_result;

    always_comb begin
        in_sign_a   = is_signed_a(mdu_fun) & srcA[XLEN-1];
        in_sign_b   = is_signed_b(mdu_fun) & srcB[XLEN-1];
        a_mag       = in_sign_a ? (~srcA + 1'b1) : srcA;
        b_mag       = in_sign_b ? (~srcB + 1'b1) : srcB;
        div_zero    = (srcB == '0);
        div_ovf     = ((mdu_fun == FUN_DIV) || (mdu_fun == FUN_REM)) &&
                      (srcA == MIN_NEG) && (srcB == '1);
        fast_path   = is_div(mdu_fun) && (div_zero || div_ovf);
        fast_result = '0;
        if (div_zero) begin
            fast_result = is_rem(mdu_fun) ? srcA : '1;
        end else begin
            fast_result = is_rem(mdu_fun) ? '0 : MIN_NEG;
        end
    end

    // One iteration step of shift-add multiply or restoring divide.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift, rem_diff;
    logic              q_bit;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_shift = acc_q[2*XLEN-1:XLEN-1];
        rem_diff  = rem_shift - {1'b0, opnd_q};
        q_bit     = ~rem_diff[XLEN];
        if (is_div(fun_q)) begin
            acc_step = {(q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0]),
                        acc_q[XLEN-2:0], q_bit};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix and field selection applied to the final accumulator value.
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_signed, rem_signed, final_result;

    always_comb begin
        prod_signed = (sign_a_q ^ sign_b_q) ? (~acc_step + 1'b1) : acc_step;
        quo_signed  = (sign_a_q ^ sign_b_q) ? (~acc_step[XLEN-1:0] + 1'b1)
                                            : acc_step[XLEN-1:0];
        rem_signed  = sign_a_q ? (~acc_step[2*XLEN-1:XLEN] + 1'b1)
                               : acc_step[2*XLEN-1:XLEN];
        if (is_div(fun_q)) begin
            final_result = is_rem(fun_q) ? rem_signed : quo_signed;
        end else begin
            final_result = (fun_q == FUN_MUL) ? prod_signed[XLEN-1:0]
                                              : prod_signed[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic: accept in IDLE/DONE, iterate or abort in CALC.
    always_comb begin
        state_d  = state_q;
        fun_d    = fun_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_DONE;
                        cnt_d    = '0;
                        result_d = final_result;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (start) begin
                    fun_d    = mdu_fun_t'(mdu_fun);
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    cnt_d    = '0;
                    if (fast_path) begin
                        state_d  = ST_DONE;
                        result_d = fast_result;
                    end else begin
                        state_d = ST_CALC;
                        if (is_div(mdu_fun)) begin
                            opnd_d = b_mag;
                            acc_d  = {{XLEN{1'b0}}, a_mag};
                        end else begin
                            opnd_d = a_mag;
                            acc_d  = {{XLEN{1'b0}}, b_mag};
                        end
                    end
                end
            end
        endcase
        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            fun_q    <= FUN_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fun_q    <= fun_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_otter_mdu.sv
// Directed bench for otter_mdu: vector table plus kill/ignore/reset/back-to-back sequences.
module tb_otter_mdu;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  mdu_fun = 3'b000;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    otter_mdu #(.XLEN(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .kill(kill),
        .mdu_fun(mdu_fun), .srcA(srcA), .srcB(srcB),
        .busy(busy), .done(done), .result(result)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        fast;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Drives a request now (caller is just after a rising edge) and measures
    // latency to done plus cycles of busy. inject_at>0 pulses a second start
    // with different operands during CALC.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, output int lat, output int busy_cnt,
                         output logic [31:0] res);
        start = 1'b1; mdu_fun = f; srcA = a; srcB = b;
        @(posedge CLK); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0; res = 'x;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = c; res = result;
                break;
            end
            if (c == inject_at) begin
                start = 1'b1; mdu_fun = 3'b101; srcA = 32'd100; srcB = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
        end
        start = 1'b0;
        $display("op fun=%0d a=0x%08h b=0x%08h -> result=0x%08h latency=%0d busy_cycles=%0d",
                 f, a, b, res, lat, busy_cnt);
    endtask

    initial begin
        int lat, bc, dcnt;
        logic [31:0] res;

        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       1'b0};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        1'b0};
        vecs[8]  = '{3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{3'b110, 32'h1234,     32'd0,        32'h1234,     1'b1};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[12] = '{3'b000, 32'h12345678, 32'h10,       32'h23456780, 1'b0};
        vecs[13] = '{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};
        vecs[14] = '{3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        1'b0};
        vecs[15] = '{3'b001, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 1'b0};
        vecs[16] = '{3'b011, 32'h00010000, 32'h00030000, 32'h00000003, 1'b0};

        // Reset state
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;

        // Table-driven vectors
        for (int i = 0; i < 17; i++) begin
            do_op(vecs[i].fun, vecs[i].a, vecs[i].b, 0, lat, bc, res);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].fast ? 32'd1 : 32'd33);
            chk($sformatf("vec%0d_busy", i), bc, vecs[i].fast ? 32'd0 : 32'd32);
            @(posedge CLK); #1;
        end

        // Establish a known result, then kill a MUL mid-flight
        do_op(3'b000, 32'd3, 32'd5, 0, lat, bc, res);
        chk("kill_setup", res, 32'd15);
        @(posedge CLK); #1;
        start = 1'b1; mdu_fun = 3'b000; srcA = 32'd7; srcB = 32'd9;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #1 kill = 1'b1;
        @(posedge CLK); #1;
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        chk("kill_done", {31'd0, done}, 32'd0);
        dcnt = 0;
        repeat (40) begin
            if (done) dcnt++;
            @(posedge CLK); #1;
        end
        chk("kill_no_done", dcnt, 32'd0);
        chk("kill_result_held", result, 32'd15);
        $display("kill sequence: result=0x%08h done_pulses=%0d", result, dcnt);

        // Start during CALC is ignored
        do_op(3'b000, 32'd6, 32'd7, 5, lat, bc, res);
        chk("ignore_result", res, 32'd42);
        chk("ignore_latency", lat, 32'd33);
        @(posedge CLK); #1;
        chk("ignore_no_reaccept", {30'd0, busy, done}, 32'd0);

        // Asynchronous reset mid-CALC
        start = 1'b1; mdu_fun = 3'b011; srcA = 32'd11; srcB = 32'd13;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_done", {31'd0, done}, 32'd0);
        chk("areset_result", result, 32'd0);
        $display("async reset: busy=%0b done=%0b result=0x%08h", busy, done, result);
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;

        // Back-to-back: second start sampled while in DONE
        do_op(3'b101, 32'd100, 32'd7, 0, lat, bc, res);
        chk("b2b_first", res, 32'd14);
        do_op(3'b111, 32'd100, 32'd7, 0, lat, bc, res);
        chk("b2b_second", res, 32'd2);
        chk("b2b_latency", lat, 32'd33);
        chk("b2b_busy", bc, 32'd32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
